axis_tx: RTL and testbench

Outbound AXI-Stream framer for the ODIN lab wrapper, and the counterpart of the inbound stream decoder. It accepts output spike events from the ODIN core over the four-phase AER output handshake, and accepts controller readback words over a valid/ready port. Both are serialized into byte frames on an 8-bit AXI-Stream master, using the same header-byte conventions as the inbound command stream. There is one single-entry buffer per source, so one event can be accepted while another frame is in flight.

---
 rtl/axis_tx.sv | 138 +++++++++++++
 tb/tb_axis_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tx.sv
// Outbound AXI-Stream framer: serializes AER spike events and controller readback
// words into header-tagged byte frames on an 8-bit stream master.
module axis_tx #(
    parameter logic [1:0] AER_HDR = 2'b11,
    parameter logic [1:0] RB_HDR  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic [7:0]  AEROUT_ADDR,
    input  logic        AEROUT_REQ,
    output logic        AEROUT_ACK,
    input  logic [11:0] RB_ADDR,
    input  logic [7:0]  RB_DATA,
    input  logic        RB_VALID,
    output logic        RB_READY,
    output logic        TX_BUSY
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      r_state;
    logic [7:0]  r_aer_buf;
    logic        r_aer_full;
    logic        r_ack;
    logic [11:0] r_rb_addr;
    logic [7:0]  r_rb_data;
    logic        r_rb_full;
    logic [7:0]  r_tdata;
    logic [7:0]  r_nxt0;
    logic [7:0]  r_nxt1;
    logic        r_tvalid;
    logic        r_tlast;
    logic [1:0]  r_left;

    logic w_aer_cap;
    logic w_rb_cap;
    logic w_aer_load;
    logic w_rb_load;
    logic w_xfer;

    assign w_aer_cap  = AEROUT_REQ && !r_ack && !r_aer_full;
    assign w_rb_cap   = RB_VALID && !r_rb_full;
    // AER wins when both buffers are full at the moment the framer goes idle.
    assign w_aer_load = (r_state == S_IDLE) && r_aer_full;
    assign w_rb_load  = (r_state == S_IDLE) && !r_aer_full && r_rb_full;
    assign w_xfer     = r_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aer_buf  <= 8'h00;
            r_aer_full <= 1'b0;
            r_ack      <= 1'b0;
        end else if (w_aer_cap) begin
            r_aer_buf  <= AEROUT_ADDR;
            r_aer_full <= 1'b1;
            r_ack      <= 1'b1;
        end else begin
            if (r_ack && !AEROUT_REQ)
                r_ack <= 1'b0;
            if (w_aer_load)
                r_aer_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_addr <= 12'h000;
            r_rb_data <= 8'h00;
            r_rb_full <= 1'b0;
        end else if (w_rb_cap) begin
            r_rb_addr <= RB_ADDR;
            r_rb_data <= RB_DATA;
            r_rb_full <= 1'b1;
        end else if (w_rb_load) begin
            r_rb_full <= 1'b0;
        end
    end

    // r_left counts bytes still queued behind the one currently on tdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tdata  <= 8'h00;
            r_nxt0   <= 8'h00;
            r_nxt1   <= 8'h00;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_left   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aer_load) begin
                        r_tdata  <= {AER_HDR, 6'b0};
                        r_nxt0   <= r_aer_buf;
                        r_nxt1   <= 8'h00;
                        r_left   <= 2'd1;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= S_SEND;
                    end else if (w_rb_load) begin
                        r_tdata  <= {RB_HDR, 2'b00, r_rb_addr[11:8]};
                        r_nxt0   <= r_rb_addr[7:0];
                        r_nxt1   <= r_rb_data;
                        r_left   <= 2'd2;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_tdata <= r_nxt0;
                            r_nxt0  <= r_nxt1;
                            r_tlast <= (r_left == 2'd1);
                            r_left  <= r_left - 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign AEROUT_ACK    = r_ack;
    assign RB_READY      = !r_rb_full;
    assign TX_BUSY       = (r_state == S_SEND);
endmodule

// File: tb/tb_axis_tx.sv
// Bench for axis_tx: directed frames plus randomized back-pressure, checked against
// a queue of expected bytes built from the frame formats.
module tb_axis_tx;
    logic        gclk = 1'b0;
    logic        rst;
    logic [7:0]  tdata;
    logic        tvalid, tready, tlast;
    logic [7:0]  aer_addr;
    logic        aer_req, aer_ack;
    logic [11:0] rb_addr;
    logic [7:0]  rb_data;
    logic        rb_valid, rb_ready, tx_busy;

    logic        tready_set = 1'b1;
    logic        rnd_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          acks = 0;
    int          loads = 0;
    logic [8:0]  exp_q[$];

    logic        prev_stall = 1'b0, prev_last = 1'b0, prev_vld = 1'b0, prev_ack = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_tlast = 1'b0;

    axis_tx dut (
        .clk(gclk), .rst(rst),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast),
        .AEROUT_ADDR(aer_addr), .AEROUT_REQ(aer_req), .AEROUT_ACK(aer_ack),
        .RB_ADDR(rb_addr), .RB_DATA(rb_data), .RB_VALID(rb_valid), .RB_READY(rb_ready),
        .TX_BUSY(tx_busy)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // tready is driven 2 time units after each edge so test code set at +1 takes effect that cycle
    always @(posedge gclk) begin
        #2;
        tready = rnd_mode ? 1'($urandom_range(1, 0)) : tready_set;
    end

    // Monitor: values sampled mid-cycle equal those seen at the following rising edge.
    always @(negedge gclk) begin
        if (rst) begin
            prev_stall = 1'b0; prev_last = 1'b0; prev_vld = 1'b0; prev_ack = 1'b0;
            acks = 0; loads = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", tvalid, 1);
                chk("hold_data", tdata, prev_data);
                chk("hold_last", tlast, prev_tlast);
            end
            if (prev_last)
                chk("frame_gap", tvalid, 0);
            if (aer_ack && !prev_ack) begin
                acks++;
                chk("ack_withheld", (acks - loads <= 1), 1);
            end
            if (tvalid && !prev_vld && tdata[7:6] == 2'b11)
                loads++;
            if (tvalid && tready) begin
                chk("byte_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e[7:0]);
                    chk("tlast", tlast, e[8]);
                end
                xfers++;
            end
            prev_stall = tvalid && !tready;
            prev_last  = tvalid && tready && tlast;
            prev_vld   = tvalid;
            prev_ack   = aer_ack;
            prev_data  = tdata;
            prev_tlast = tlast;
        end
    end

    task automatic tick();
        @(posedge gclk); #1;
    endtask

    task automatic push_aer(input logic [7:0] a);
        exp_q.push_back({1'b0, 2'b11, 6'b0});
        exp_q.push_back({1'b1, a});
    endtask

    task automatic push_rb(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back({1'b0, 2'b01, 2'b00, a[11:8]});
        exp_q.push_back({1'b0, a[7:0]});
        exp_q.push_back({1'b1, d});
    endtask

    task automatic aer_event(input logic [7:0] a);
        int n;
        push_aer(a);
        aer_addr = a; aer_req = 1'b1;
        n = 0;
        while (!aer_ack && n < 300) begin tick(); n++; end
        chk("ack_rise", aer_ack, 1);
        aer_req = 1'b0;
        n = 0;
        while (aer_ack && n < 10) begin tick(); n++; end
        chk("ack_fall", aer_ack, 0);
    endtask

    task automatic rb_send(input logic [11:0] a, input logic [7:0] d);
        int n;
        push_rb(a, d);
        rb_addr = a; rb_data = d; rb_valid = 1'b1;
        n = 0;
        while (!rb_ready && n < 300) begin tick(); n++; end
        chk("rb_ready_wait", rb_ready, 1);
        tick();
        rb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid || tx_busy) && n < 3000) begin tick(); n++; end
        chk("drained", (exp_q.size() == 0 && !tvalid && !tx_busy), 1);
    endtask

    initial begin
        int n, x0;
        rst = 1'b1; aer_addr = 8'h00; aer_req = 1'b0;
        rb_addr = 12'h000; rb_data = 8'h00; rb_valid = 1'b0;
        tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_ack", aer_ack, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rb_ready", rb_ready, 1);
        tick(); rst = 1'b0; tick();

        // Single AER event with latency checks
        push_aer(8'h5A);
        aer_addr = 8'h5A; aer_req = 1'b1;
        tick();
        chk("aer_ack_1cyc", aer_ack, 1);
        chk("aer_vld_early", tvalid, 0);
        tick();
        chk("aer_vld", tvalid, 1);
        chk("aer_hdr", tdata, 8'hC0);
        chk("aer_busy", tx_busy, 1);
        aer_req = 1'b0;
        tick();
        chk("aer_ack_drop", aer_ack, 0);
        wait_idle();

        // Readback frame, RB_READY low exactly one cycle
        push_rb(12'hABC, 8'h3E);
        rb_addr = 12'hABC; rb_data = 8'h3E; rb_valid = 1'b1;
        tick();
        rb_valid = 1'b0;
        chk("rb_ready_low", rb_ready, 0);
        tick();
        chk("rb_ready_back", rb_ready, 1);
        chk("rb_vld", tvalid, 1);
        chk("rb_hdr", tdata, 8'h4A);
        wait_idle();

        // Simultaneous sources: AER first, then readback after a gap
        push_aer(8'h01);
        push_rb(12'h010, 8'hFF);
        aer_addr = 8'h01; aer_req = 1'b1;
        rb_addr = 12'h010; rb_data = 8'hFF; rb_valid = 1'b1;
        tick();
        rb_valid = 1'b0;
        chk("sim_ack", aer_ack, 1);
        aer_req = 1'b0;
        wait_idle();

        // Random back-pressure, three AER events back-to-back per round, then readbacks
        rnd_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) aer_event(8'($urandom));
            wait_idle();
        end
        for (int k = 0; k < 4; k++) rb_send(12'($urandom), 8'($urandom));
        wait_idle();
        rnd_mode = 1'b0;
        tick();

        // Reset after the header byte of an AER frame is accepted, REQ held high
        tready_set = 1'b1;
        push_aer(8'h77);
        aer_addr = 8'h77; aer_req = 1'b1;
        x0 = xfers; n = 0;
        while (xfers == x0 && n < 50) begin tick(); n++; end
        chk("hdr_seen", (xfers != x0), 1);
        rst = 1'b1; tready_set = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_ack", aer_ack, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_rb_ready", rb_ready, 1);
        exp_q.delete();
        tready_set = 1'b1;
        aer_event(8'h77);
        wait_idle();

        // Stall persistence: readback frame held for 20 cycles
        tready_set = 1'b0;
        tick();
        rb_send(12'h123, 8'h99);
        n = 0;
        while (!tvalid && n < 20) begin tick(); n++; end
        chk("stall_vld", tvalid, 1);
        repeat (20) tick();
        chk("stall_hold", tdata, 8'h41);
        chk("stall_vld_held", tvalid, 1);
        tready_set = 1'b1;
        wait_idle();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
